uart_rx_frame: RTL
==================

# uart_rx_frame

Serial receive framer for the UART path. It detects a start bit on the asynchronous `rxd` line and requests bit timing from the baud-rate generator by holding `bps_start` high for the duration of the frame. It samples one bit per mid-bit `bps_clk` pulse from that generator, then presents each completed character as a one-cycle `rx_valid` strobe with error flags.

## Interface
Parameters:
- `DATA_BITS`, default 8: character length, legal range 5..8.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rxd`  in  1  serial line, asynchronous to `clk`, idles high.
- `bps_clk`  in  1  one-cycle mid-bit sample pulse from the baud generator.
- `bps_start`  out  1  high while a frame is in progress; enables the baud generator.
- `rx_data`  out  DATA_BITS  last received character, LSB = first bit on the line.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` updated, stop bit good.
- `frame_err`  out  1  one-cycle strobe: stop bit sampled low.
- `parity_err`  out  1  one-cycle strobe, coincident with `rx_valid`: parity mismatch.
- `rx_busy`  out  1  state is not IDLE.

## Operation
- **Synchroniser:** `rxd` passes through 2 flops (`s1`, `s2`). A third flop `s3` is used for edge detection. All three reset to 1. All sampling uses `s2`.
- **Start edge:** `s3==1 && s2==0`.
- **States:** IDLE, START, DATA, PARITY (macro only), STOP.
- **IDLE:** `bps_start=0`. `bps_clk` is ignored. On a start edge, go to START and set `bps_start=1` (registered).
- **START:** on `bps_clk`:
  - If `s2==0`, go to DATA and set `bit_cnt=0`.
  - Otherwise it is a false start: go to IDLE and clear `bps_start`. No strobes are produced.
- **DATA:** on each `bps_clk`, `shreg <= {s2, shreg[DATA_BITS-1:1]}` and `bit_cnt++`. After the `DATA_BITS`-th sample, go to PARITY (if enabled) or STOP.
- **PARITY:** on `bps_clk`, latch `par_bad = s2 ^ (^shreg)` (even parity) and go to STOP.
- **STOP:** on `bps_clk`:
  - Always: `rx_data <= shreg`, clear `bps_start`, go to IDLE.
  - If `s2==1`: assert `rx_valid` for one cycle, with `parity_err = par_bad`.
  - If `s2==0`: assert `frame_err` for one cycle; `rx_valid` and `parity_err` stay 0.
- **Edges while busy:** start edges outside IDLE are ignored.
- **Break / stop low:** a new frame needs a real high-to-low transition after returning to IDLE, so a line held low does not retrigger.
- **`bit_cnt` width:** 3 bits, compared against `DATA_BITS-1`.

## Timing
- **Reset values:** `bps_start=0`, `rx_data=0`, `rx_valid=0`, `frame_err=0`, `parity_err=0`, `rx_busy=0`, state=IDLE. Reset mid-frame aborts immediately; no strobe is produced.
- **Edge detection:** `bps_start` rises 3 clk after the `rxd` falling edge (2 sync flops + registered output).
- **Generator behaviour:** the baud generator (434-count period) gives its first `bps_clk` about 218 clk after `bps_start` rises, then one every 434 clk.
- **Strobe timing:**
  - Strobes assert the cycle after the STOP-state `bps_clk`; `rx_data` is valid the same cycle.
  - Strobes last exactly 1 cycle.
  - `bps_start` falls in the same cycle the strobes assert.
- **Back-to-back frames:** the generator counter clears while `bps_start=0`. The next start edge (at least about 217 clk after the stop sample) restarts cleanly.
- **Frame latency:** from start edge to `rx_valid` ≈ (1 + DATA_BITS [+1] + 0.5) × 434 clk. With 8N1 this is ≈ 4123 clk.

## Configuration
- **`UART_RX_PARITY_EN` defined:** the PARITY state exists and one even-parity bit is expected between the data and stop bits. `parity_err` is driven as described above.
- **`UART_RX_PARITY_EN` undefined:** the PARITY state is absent, the frame is 1 start + `DATA_BITS` + 1 stop, and `parity_err` is tied to 0. The port list is unchanged.

## Test plan
All scenarios use `DATA_BITS=8` and a real baud generator with a bit period of 434 clk.

1. **Single frame:** drive 0x55, 8N1 → one `rx_valid` pulse, `rx_data=0x55`, `frame_err=0`, `bps_start` low afterwards.
2. **Back-to-back:** 0xA3 then 0x3C with no idle gap → exactly two `rx_valid` pulses, values 0xA3 then 0x3C.
3. **Glitch:** `rxd` low for 100 clk, then high → `bps_start` pulses high then returns to 0 at the first `bps_clk`; no strobes; `rx_busy` returns to 0.
4. **Bad stop bit:** 0xFF with the stop bit low and the line held low afterwards → `frame_err` one pulse, `rx_valid=0`, `rx_data=0xFF`; no new frame until the line goes high and then falls.
5. **Parity:** with `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 → `rx_valid=1`, `parity_err=1`, `rx_data=0x07`; with parity bit 1 → `parity_err=0`. Without the macro, 8N1 0x07 → `parity_err` stays 0.
6. **Reset mid-frame:** assert `rst_n` low during the 4th data bit → all outputs 0 and state IDLE; then a clean 0xC9 frame → `rx_data=0xC9`, `rx_valid` one pulse.

Source files
------------

// File: rtl/uart_rx_frame.sv
// UART receive framer: start-bit detection, mid-bit sampling on bps_clk, and per-character strobes.
// Optional even-parity bit between data and stop is enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    input  logic                 bps_clk,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state;
    state_t               state_next;
    logic                 s1;
    logic                 s2;
    logic                 s3;
    logic                 start_edge;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 clr_cnt;
    logic                 shift_en;
    logic                 stop_sample;
`ifdef UART_RX_PARITY_EN
    logic                 par_ld;
    logic                 par_bad;
`endif

    // Only a genuine high-to-low transition starts a frame, so a line stuck low cannot retrigger.
    assign start_edge = s3 && !s2;
    assign rx_busy    = (state != IDLE);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_next  = state;
        clr_cnt     = 1'b0;
        shift_en    = 1'b0;
        stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_ld      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start_edge) state_next = START;
            end
            START: begin
                if (bps_clk) begin
                    if (!s2) begin
                        state_next = DATA;
                        clr_cnt    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (bps_clk) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bps_clk) begin
                    par_ld     = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bps_clk) begin
                    stop_sample = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= 1'b1;
            s2        <= 1'b1;
            s3        <= 1'b1;
            state     <= IDLE;
            bps_start <= 1'b0;
            bit_cnt   <= 3'd0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            s1        <= rxd;
            s2        <= s1;
            s3        <= s2;
            state     <= state_next;
            bps_start <= (state_next != IDLE);

            if (clr_cnt) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            // LSB arrives first, so shift in from the top.
            if (shift_en) shreg <= {s2, shreg[DATA_BITS-1:1]};

            if (stop_sample) rx_data <= shreg;
            rx_valid  <= stop_sample && s2;
            frame_err <= stop_sample && !s2;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (clr_cnt) begin
                par_bad <= 1'b0;
            end else if (par_ld) begin
                par_bad <= s2 ^ (^shreg);
            end
            parity_err <= stop_sample && s2 && par_bad;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
